// File: rtl/dna_pkg.sv
// Shared DNA base definitions: 2-bit base codes, their ASCII letters and the
// code-to-letter map used by both the k-mer hash encoder and the decoder.
package dna_pkg;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  localparam logic [7:0] ASCII_A = 8'd65;
  localparam logic [7:0] ASCII_C = 8'd67;
  localparam logic [7:0] ASCII_G = 8'd71;
  localparam logic [7:0] ASCII_T = 8'd84;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } dec_state_t;

  function automatic logic [7:0] code2ascii(input logic [1:0] code);
    logic [7:0] ch;
    case (code)
      BASE_A:  ch = ASCII_A;
      BASE_C:  ch = ASCII_C;
      BASE_G:  ch = ASCII_G;
      default: ch = ASCII_T;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/dna_code_to_ascii.sv
// Combinational lookup from a 2-bit base code to its ASCII letter.
module dna_code_to_ascii
  import dna_pkg::*;
(
  input  logic [1:0] code,
  output logic [7:0] ascii
);

  assign ascii = code2ascii(code);

endmodule

// File: rtl/dna_base4_decoder.sv
// Serialises one packed base-4 k-mer hash back into ASCII bases, first base
// first, one per accepted beat; a new hash may load on the last-beat cycle.
module dna_base4_decoder
  import dna_pkg::*;
#(
  parameter int K      = 4,
  parameter int HASH_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HASH_W-1:0] hash_in,
  input  logic              hash_valid,
  output logic              hash_ready,
  output logic [7:0]        char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              char_last,
  output logic              busy
);

  localparam int SW = 2 * K;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

  dec_state_t    state, state_nxt;
  logic [SW-1:0] shift_q, shift_nxt;
  logic [CW-1:0] count_q, count_nxt;
  logic          load;
  logic          beat;

  generate
    if (HASH_W > SW) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^hash_in[HASH_W-1:SW];
    end
  endgenerate

  // hash_ready depends on char_ready in the last-beat cycle so k-mers can
  // stream back to back without a bubble.
  always_comb begin
    busy       = (state == ST_SHIFT);
    char_valid = busy;
    char_last  = busy && (count_q == LAST_IDX);
    hash_ready = !busy || (char_last && char_ready);
    load       = hash_valid && hash_ready;
    beat       = char_valid && char_ready;
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    count_nxt = count_q;
    if (load) begin
      state_nxt = ST_SHIFT;
      shift_nxt = hash_in[SW-1:0];
      count_nxt = '0;
    end else if (beat) begin
      if (char_last) begin
        state_nxt = ST_IDLE;
      end else begin
        shift_nxt = shift_q << 2;
        count_nxt = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      state   <= state_nxt;
      shift_q <= shift_nxt;
      count_q <= count_nxt;
    end
  end

  dna_code_to_ascii u_lut (
    .code  (shift_q[SW-1 -: 2]),
    .ascii (char_out)
  );

endmodule

// File: tb/tb_dna_base4_decoder.sv
// Scoreboard bench for dna_base4_decoder: accepted hashes are expanded by a
// reference model into expected characters, popped as the DUT emits them.
module tb_dna_base4_decoder;

  localparam int K      = 4;
  localparam int HASH_W = 32;

  logic              clk;
  logic              rst_n;
  logic [HASH_W-1:0] hash_in;
  logic              hash_valid;
  logic              hash_ready;
  logic [7:0]        char_out;
  logic              char_valid;
  logic              char_ready;
  logic              char_last;
  logic              busy;

  typedef struct {
    logic [7:0] ch;
    logic       last;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] ch;
    logic       last;
  } beat_t;

  exp_t  sb[$];
  beat_t beatLog[$];
  int    errCount   = 0;
  int    checkCount = 0;
  int    cyc        = 0;
  int    acceptCyc  = 0;
  bit    stallPrev  = 0;
  logic [7:0] stallChar;
  logic       stallLast;

  dna_base4_decoder #(.K(K), .HASH_W(HASH_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hash_in    (hash_in),
    .hash_valid (hash_valid),
    .hash_ready (hash_ready),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_last  (char_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] modelAscii(input logic [1:0] code);
    case (code)
      2'd0:    return 8'h41;
      2'd1:    return 8'h43;
      2'd2:    return 8'h47;
      default: return 8'h54;
    endcase
  endfunction

  task automatic pushModel(input logic [HASH_W-1:0] h);
    exp_t e;
    for (int i = 0; i < K; i++) begin
      e.ch   = modelAscii(h[2*(K-1-i) +: 2]);
      e.last = (i == K - 1);
      sb.push_back(e);
    end
  endtask

  // Handshakes are sampled on the falling edge, so they describe the transfer
  // that the following rising edge will commit.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hash_valid && hash_ready) pushModel(hash_in);
      if (stallPrev) begin
        checkOutput("bp_valid", 32'(char_valid), 32'd1);
        checkOutput("bp_char", 32'(char_out), 32'(stallChar));
        checkOutput("bp_last", 32'(char_last), 32'(stallLast));
      end
      if (char_valid && char_ready) begin
        beat_t b;
        b.cyc  = cyc;
        b.ch   = char_out;
        b.last = char_last;
        beatLog.push_back(b);
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sb_char", 32'(char_out), 32'(e.ch));
          checkOutput("sb_last", 32'(char_last), 32'(e.last));
        end
      end
      stallPrev = char_valid && !char_ready;
      stallChar = char_out;
      stallLast = char_last;
    end else begin
      stallPrev = 0;
    end
  end

  always @(negedge rst_n) sb.delete();

  task automatic applyStimulus(input logic [HASH_W-1:0] h, input bit hold);
    bit accepted;
    accepted   = 0;
    hash_in    = h;
    hash_valid = 1'b1;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      if (hash_ready) begin
        accepted  = 1;
        acceptCyc = cyc;
      end
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold || !accepted) hash_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb.size() != 0 || char_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || char_valid) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic checkSeq(input string tag, input string s, input bit consec);
    checkOutput({tag, "_len"}, 32'(beatLog.size()), 32'(s.len()));
    for (int i = 0; i < s.len() && i < beatLog.size(); i++) begin
      checkOutput($sformatf("%s_ch%0d", tag, i), 32'(beatLog[i].ch), 32'(s[i]));
      checkOutput($sformatf("%s_last%0d", tag, i), 32'(beatLog[i].last), 32'((i % K) == K - 1));
      if (consec)
        checkOutput($sformatf("%s_cyc%0d", tag, i), 32'(beatLog[i].cyc - beatLog[0].cyc), 32'(i));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    hash_in    = '0;
    hash_valid = 1'b0;
    char_ready = 1'b1;
    #1;
    checkOutput("rst_char_valid", 32'(char_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_char_last", 32'(char_last), 32'd0);
    checkOutput("rst_char_out", 32'(char_out), 32'd65);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_hash_ready", 32'(hash_ready), 32'd1);

    $display("[TB] basic 32'h36");
    beatLog.delete();
    applyStimulus(32'h36, 0);
    waitDrain();
    checkSeq("t1", "ATCG", 1);
    if (beatLog.size() > 0) checkOutput("t1_latency", 32'(beatLog[0].cyc - acceptCyc), 32'd1);
    checkOutput("t1_hash_ready", 32'(hash_ready), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd0);

    $display("[TB] upper bits ignored");
    beatLog.delete();
    applyStimulus(32'hFFFF_FF1B, 0);
    waitDrain();
    checkSeq("t2", "ACGT", 1);

    $display("[TB] backpressure");
    beatLog.delete();
    applyStimulus(32'h36, 0);
    @(posedge clk);
    #1;
    char_ready = 1'b0;
    checkOutput("t3_stall_char", 32'(char_out), 32'd84);
    checkOutput("t3_stall_valid", 32'(char_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    char_ready = 1'b1;
    waitDrain();
    checkSeq("t3", "ATCG", 0);

    $display("[TB] back-to-back");
    beatLog.delete();
    applyStimulus(32'h00, 1);
    applyStimulus(32'hFF, 0);
    waitDrain();
    checkSeq("t4", "AAAATTTT", 1);

    $display("[TB] reset mid k-mer");
    beatLog.delete();
    applyStimulus(32'h36, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_char_valid", 32'(char_valid), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_char_last", 32'(char_last), 32'd0);
    checkOutput("t5_char_out", 32'(char_out), 32'd65);
    checkSeq("t5a", "AT", 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beatLog.delete();
    applyStimulus(32'h9C, 0);
    waitDrain();
    checkSeq("t5b", "GCTA", 1);

    $display("[TB] hash offered while busy");
    beatLog.delete();
    applyStimulus(32'h36, 1);
    hash_in = 32'h1B;
    @(negedge clk);
    checkOutput("t6_busy_ready", 32'(hash_ready), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd1);
    applyStimulus(32'h1B, 0);
    waitDrain();
    checkSeq("t6", "ATCGACGT", 1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
